// File: rtl/ahb_sdram_slave_if_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ahb_sdram_slave_if_if
// Bundle of every signal between the AHB-Lite slave front end and the outside
// world: the AHB-Lite slave port on one side and the SDRAM controller's
// valid/ready request port on the other.
//
//   AHB side     : hsel, haddr, htrans, hwrite, hsize, hready, hwdata (to slave)
//                  hrdata, hreadyout, hresp                             (from slave)
//   Memory side  : mem_addr, enable, w_en, r_en, wr_data              (from slave)
//                  busy_n, rd_data, rd_valid                           (to slave)
//
// modport slave  : the front end itself.
// modport master : the surrounding system (bus master plus controller).
// -----------------------------------------------------------------------------
interface ahb_sdram_slave_if_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    // AHB-Lite
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic              hready;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hreadyout;
    logic              hresp;

    // SDRAM controller request port
    logic [ADDR_W-1:0] mem_addr;
    logic              enable;
    logic              w_en;
    logic              r_en;
    logic [DATA_W-1:0] wr_data;
    logic              busy_n;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
        output hrdata, hreadyout, hresp,
        output mem_addr, enable, w_en, r_en, wr_data,
        input  busy_n, rd_data, rd_valid
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
        input  hrdata, hreadyout, hresp,
        input  mem_addr, enable, w_en, r_en, wr_data,
        output busy_n, rd_data, rd_valid
    );
endinterface

// File: rtl/ahb_sdram_slave_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ahb_sdram_slave_if
// AHB-Lite slave front end for the SDRAM controller. Accepts single-word
// transfers, checks address window / alignment / size, and turns every valid
// transfer into exactly one valid/ready request toward the controller while
// holding the AHB data phase with hreadyout. Invalid transfers get the
// two-cycle AHB ERROR response and never reach the controller.
//
// Ports:
//   hclk : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : ahb_sdram_slave_if_if.slave (AHB slave port + controller request port)
//
// Parameters:
//   ADDR_W    : word-address width toward the controller
//   DATA_W    : bus / memory data width
//   BASE_ADDR : byte base of the window; only bits [31:ADDR_W+2] are decoded
// -----------------------------------------------------------------------------
module ahb_sdram_slave_if #(
    parameter int          ADDR_W    = 12,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic                 hclk,
    input logic                 rst,
    ahb_sdram_slave_if_if.slave bus
);

    localparam int TAG_LSB = ADDR_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              hwrite_reg,   hwrite_next;
    logic [DATA_W-1:0] wr_data_reg,  wr_data_next;
    logic              enable_reg,   enable_next;
    logic              w_en_reg,     w_en_next;
    logic              r_en_reg,     r_en_next;
    logic [DATA_W-1:0] hrdata_reg,   hrdata_next;

    logic hreadyout_dec;
    logic hresp_dec;

    // Address-phase decode
    logic acc;
    logic addr_hit;
    logic addr_aligned;
    logic size_word;
    logic xfer_ok;

    // htrans[0] only separates NONSEQ from SEQ, which this slave treats alike.
    logic unused_htrans_lsb;
    assign unused_htrans_lsb = bus.htrans[0];

    assign acc          = bus.hsel & bus.hready & bus.htrans[1];
    assign addr_hit     = (bus.haddr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign addr_aligned = (bus.haddr[1:0] == 2'b00);
    assign size_word    = (bus.hsize == 3'b010);
    assign xfer_ok      = addr_hit & addr_aligned & size_word;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            mem_addr_reg <= '0;
            hwrite_reg   <= 1'b0;
            wr_data_reg  <= '0;
            enable_reg   <= 1'b0;
            w_en_reg     <= 1'b0;
            r_en_reg     <= 1'b0;
            hrdata_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            mem_addr_reg <= mem_addr_next;
            hwrite_reg   <= hwrite_next;
            wr_data_reg  <= wr_data_next;
            enable_reg   <= enable_next;
            w_en_reg     <= w_en_next;
            r_en_reg     <= r_en_next;
            hrdata_reg   <= hrdata_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, next-register values and state-decoded AHB response
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        mem_addr_next = mem_addr_reg;
        hwrite_next   = hwrite_reg;
        wr_data_next  = wr_data_reg;
        enable_next   = enable_reg;
        w_en_next     = w_en_reg;
        r_en_next     = r_en_reg;
        hrdata_next   = hrdata_reg;
        hreadyout_dec = 1'b1;
        hresp_dec     = 1'b0;

        case (state_reg)
            // States in which the data phase is (or is about to be) complete,
            // so a new address phase may be taken. ERR2 differs only in hresp.
            ST_IDLE, ST_DONE, ST_ERR2: begin
                hresp_dec = (state_reg == ST_ERR2);
                if (acc) begin
                    if (xfer_ok) begin
                        state_next    = ST_CAPTURE;
                        mem_addr_next = bus.haddr[ADDR_W+1:2];
                        hwrite_next   = bus.hwrite;
                    end else begin
                        state_next = ST_ERR1;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end

            // hwdata is only valid now (data phase), so the request is built
            // one cycle after the address was accepted.
            ST_CAPTURE: begin
                hreadyout_dec = 1'b0;
                if (hwrite_reg) begin
                    wr_data_next = bus.hwdata;
                end
                enable_next = 1'b1;
                w_en_next   = hwrite_reg;
                r_en_next   = ~hwrite_reg;
                state_next  = ST_ISSUE;
            end

            // Request held stable until the controller takes it.
            ST_ISSUE: begin
                hreadyout_dec = 1'b0;
                if (bus.busy_n) begin
                    enable_next = 1'b0;
                    w_en_next   = 1'b0;
                    r_en_next   = 1'b0;
                    state_next  = hwrite_reg ? ST_DONE : ST_WAIT_RD;
                end
            end

            ST_WAIT_RD: begin
                hreadyout_dec = 1'b0;
                if (bus.rd_valid) begin
                    hrdata_next = bus.rd_data;
                    state_next  = ST_DONE;
                end
            end

            // First cycle of the two-cycle ERROR response.
            ST_ERR1: begin
                hreadyout_dec = 1'b0;
                hresp_dec     = 1'b1;
                state_next    = ST_ERR2;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.hreadyout = hreadyout_dec;
    assign bus.hresp     = hresp_dec;
    assign bus.hrdata    = hrdata_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.enable    = enable_reg;
    assign bus.w_en      = w_en_reg;
    assign bus.r_en      = r_en_reg;
    assign bus.wr_data   = wr_data_reg;

endmodule

// File: tb/tb_ahb_sdram_slave_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ahb_sdram_slave_if
// Self-checking bench for ahb_sdram_slave_if. A sequential AHB master drives
// directed and random transfers; a controller responder process plays the
// SDRAM controller (random stall / read latency, its own memory array) and
// checks every request against what the master expects. The master's
// reference memory and wait-state arithmetic come straight from the
// transfer rules, not from the design's state machine.
// -----------------------------------------------------------------------------
module tb_ahb_sdram_slave_if;

    localparam int          ADDR_W    = 12;
    localparam int          DATA_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int          WORDS     = 1 << ADDR_W;

    logic hclk = 1'b0;
    logic rst  = 1'b1;

    always #5 hclk = ~hclk;

    ahb_sdram_slave_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ahb_sdram_slave_if #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .hclk(hclk),
        .rst (rst),
        .bus (bus)
    );

    // Bookkeeping
    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    // Reference model (master view) and device memory (controller view)
    logic [DATA_W-1:0] ref_mem [WORDS];
    logic [DATA_W-1:0] sdram   [WORDS];
    logic [DATA_W-1:0] model_rd = '0;   // value hrdata must show
    logic [DATA_W-1:0] model_wr = '0;   // value wr_data must show

    // Expectations handed from master to responder for the next request
    int                cfg_stall = 0;
    int                cfg_rdlat = 1;
    logic [ADDR_W-1:0] exp_addr  = '0;
    logic              exp_wr    = 1'b0;
    logic [DATA_W-1:0] exp_wdata = '0;
    int                exp_reqs  = 0;
    int                req_count = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Controller responder
    // -------------------------------------------------------------------------
    task automatic serve_req();
        logic [ADDR_W-1:0] a;
        logic              is_wr;
        logic [DATA_W-1:0] d;
        a     = bus.mem_addr;
        is_wr = bus.w_en;
        d     = bus.wr_data;
        bus.rd_valid = 1'b0;
        check_val("req_addr",  bus.mem_addr, exp_addr);
        check_val("req_w_en",  bus.w_en,     exp_wr);
        check_val("req_r_en",  bus.r_en,     !exp_wr);
        check_val("req_wdata", bus.wr_data,  exp_wdata);
        bus.busy_n = (cfg_stall == 0);
        for (int i = 0; i < cfg_stall; i++) begin
            @(negedge hclk);
            if (rst) begin
                bus.busy_n = 1'b1;
                return;
            end
            check_val("hold_enable", bus.enable,   1'b1);
            check_val("hold_addr",   bus.mem_addr, exp_addr);
            check_val("hold_wdata",  bus.wr_data,  exp_wdata);
        end
        bus.busy_n = 1'b1;
        @(negedge hclk);
        if (rst) return;
        check_val("strobe_drop", {bus.enable, bus.w_en, bus.r_en}, 3'b000);
        req_count++;
        if (is_wr) begin
            sdram[a] = d;
        end else begin
            for (int i = 1; i < cfg_rdlat; i++) begin
                @(negedge hclk);
                if (rst) return;
            end
            bus.rd_valid = 1'b1;
            bus.rd_data  = sdram[a];
            @(negedge hclk);
            bus.rd_valid = 1'b0;
            bus.rd_data  = $urandom;
        end
    endtask

    // Outside a request, busy_n / rd_valid / rd_data wander randomly: the
    // design must ignore them.
    initial begin : responder
        bus.busy_n   = 1'b1;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(negedge hclk);
            if (!rst && bus.enable === 1'b1) begin
                serve_req();
            end else begin
                bus.busy_n   = 1'($urandom);
                bus.rd_valid = 1'($urandom);
                bus.rd_data  = $urandom;
            end
        end
    end

    // -------------------------------------------------------------------------
    // AHB master
    // -------------------------------------------------------------------------
    task automatic idle_bus();
        bus.hsel   = 1'b0;
        bus.hready = 1'b1;
        bus.htrans = 2'b00;
        bus.haddr  = $urandom;
        bus.hwrite = 1'($urandom);
        bus.hsize  = 3'($urandom);
    endtask

    // Called at a falling edge while the slave shows hreadyout=1; returns
    // just after the falling edge of the final data-phase cycle, so calling
    // it again straight away gives a pipelined (back-to-back) transfer.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                           input logic [DATA_W-1:0] wdata, input int stall, input int rdlat);
        logic              valid;
        logic [ADDR_W-1:0] idx;
        int                exp_waits;
        int                waits;
        valid = ((addr >> (ADDR_W + 2)) == (BASE_ADDR >> (ADDR_W + 2))) &&
                (addr[1:0] == 2'b00) && (size == 3'b010);
        idx   = addr[ADDR_W+1:2];
        if (!valid)  exp_waits = 1;
        else if (wr) exp_waits = 2 + stall;
        else         exp_waits = 2 + stall + rdlat;
        cfg_stall = stall;
        cfg_rdlat = rdlat;
        exp_addr  = idx;
        exp_wr    = wr;
        exp_wdata = wr ? wdata : model_wr;
        if (valid) exp_reqs++;

        bus.hsel   = 1'b1;
        bus.hready = 1'b1;
        bus.htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
        bus.haddr  = addr;
        bus.hwrite = wr;
        bus.hsize  = size;
        @(posedge hclk);
        #1;
        idle_bus();
        bus.hwdata = wr ? wdata : DATA_W'($urandom);

        waits = 0;
        forever begin
            @(negedge hclk);
            if (bus.hreadyout === 1'b1) break;
            if (!valid && waits == 0) check_val("err_first_hresp", bus.hresp, 1'b1);
            waits++;
            if (waits > 200) begin
                check_val("xfer_timeout", 64'(waits), 64'(exp_waits));
                break;
            end
        end
        check_val("wait_states", 64'(waits), 64'(exp_waits));
        check_val("hresp", bus.hresp, !valid);
        if (valid && !wr) begin
            check_val("hrdata", bus.hrdata, ref_mem[idx]);
            model_rd = ref_mem[idx];
        end else begin
            check_val("hrdata_hold", bus.hrdata, model_rd);
        end
        if (valid && wr) begin
            ref_mem[idx] = wdata;
            model_wr     = wdata;
        end
        if (!valid) check_val("err_no_enable", bus.enable, 1'b0);
        #1;
        check_val("req_count", 64'(req_count), 64'(exp_reqs));
        n_xfer++;
        $display("[%0t] xfer %0d %s addr=%08h size=%0d data=%08h stall=%0d rdlat=%0d waits=%0d %s",
                 $time, n_xfer, wr ? "WR" : "RD", addr, size, wr ? wdata : bus.hrdata,
                 stall, rdlat, waits, valid ? "OKAY" : "ERROR");
    endtask

    // Address phase that must not be accepted (no select, IDLE/BUSY, hready low).
    task automatic do_ignored(input logic [31:0] addr);
        int kind;
        kind       = $urandom_range(0, 3);
        bus.haddr  = addr;
        bus.hwrite = 1'($urandom);
        bus.hsize  = 3'b010;
        bus.hsel   = (kind != 2);
        bus.hready = (kind != 3);
        bus.htrans = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b01 : 2'b10;
        @(posedge hclk);
        #1;
        idle_bus();
        @(negedge hclk);
        check_val("ign_hreadyout", bus.hreadyout, 1'b1);
        check_val("ign_hresp",     bus.hresp,     1'b0);
        check_val("ign_enable",    bus.enable,    1'b0);
        #1;
        check_val("ign_req_count", 64'(req_count), 64'(exp_reqs));
        n_xfer++;
        $display("[%0t] xfer %0d IGNORED kind=%0d addr=%08h", $time, n_xfer, kind, addr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_hreadyout"}, bus.hreadyout, 1'b1);
        check_val({tag, "_hresp"},     bus.hresp,     1'b0);
        check_val({tag, "_hrdata"},    bus.hrdata,    '0);
        check_val({tag, "_strobes"},   {bus.enable, bus.w_en, bus.r_en}, 3'b000);
        check_val({tag, "_mem_addr"},  bus.mem_addr,  '0);
        check_val({tag, "_wr_data"},   bus.wr_data,   '0);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin : main
        logic [31:0]       addr;
        logic [ADDR_W-1:0] idx;
        logic [2:0]        sz;
        logic [DATA_W-1:0] v;
        int                r;

        for (int i = 0; i < WORDS; i++) begin
            v          = $urandom;
            ref_mem[i] = v;
            sdram[i]   = v;
        end
        idle_bus();
        bus.hwdata = '0;

        repeat (3) @(negedge hclk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed cases
        do_xfer(32'h0000_0010, 1'b1, 3'b010, 32'hDEAD_BEEF, 0, 1);
        @(negedge hclk);
        do_xfer(32'h0000_0010, 1'b1, 3'b010, 32'hDEAD_BEEF, 3, 1);
        @(negedge hclk);
        ref_mem[12'hFFF] = 32'h1234_5678;
        sdram[12'hFFF]   = 32'h1234_5678;
        do_xfer(32'h0000_3FFC, 1'b0, 3'b010, 32'h0, 0, 2);
        @(negedge hclk);
        do_xfer(32'h0001_0000, 1'b0, 3'b010, 32'h0, 0, 1);
        @(negedge hclk);
        do_xfer(32'h0000_0010, 1'b1, 3'b000, 32'hCAFE_F00D, 0, 1);
        @(negedge hclk);
        do_xfer(32'h0000_0002, 1'b0, 3'b010, 32'h0, 0, 1);
        @(negedge hclk);
        // Back-to-back: read presented during DONE of the write to the same word
        do_xfer(32'h0000_0020, 1'b1, 3'b010, 32'hA5A5_0F0F, 1, 1);
        do_xfer(32'h0000_0020, 1'b0, 3'b010, 32'h0, 0, 1);
        // Pipelined error after error
        do_xfer(32'h0000_0021, 1'b1, 3'b010, 32'h0, 0, 1);
        do_xfer(32'h0000_0024, 1'b0, 3'b001, 32'h0, 0, 1);

        // Random traffic
        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge hclk);
            idx  = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 15))
                                              : ADDR_W'($urandom_range(0, WORDS - 1));
            addr = 32'(idx) << 2;
            sz   = 3'b010;
            r    = $urandom_range(0, 99);
            if (r < 38) begin
                do_xfer(addr, 1'b1, sz, $urandom, $urandom_range(0, 3), 1);
            end else if (r < 76) begin
                do_xfer(addr, 1'b0, sz, 32'h0, $urandom_range(0, 3), $urandom_range(1, 4));
            end else if (r < 88) begin
                case ($urandom_range(0, 2))
                    0:       addr = addr | (32'($urandom_range(1, 262143)) << 14);
                    1:       addr = addr | 32'($urandom_range(1, 3));
                    default: begin
                        sz = 3'($urandom_range(0, 6));
                        if (sz >= 3'd2) sz = sz + 3'd1;
                    end
                endcase
                do_xfer(addr, 1'($urandom), sz, $urandom, 0, 1);
            end else begin
                do_ignored(addr);
            end
        end

        // Reset in the middle of WAIT_RD
        @(negedge hclk);
        idx       = 12'h2A5;
        cfg_stall = 0;
        cfg_rdlat = 30;
        exp_addr  = idx;
        exp_wr    = 1'b0;
        exp_wdata = model_wr;
        exp_reqs++;
        bus.hsel   = 1'b1;
        bus.hready = 1'b1;
        bus.htrans = 2'b10;
        bus.haddr  = 32'(idx) << 2;
        bus.hwrite = 1'b0;
        bus.hsize  = 3'b010;
        @(posedge hclk);
        #1;
        idle_bus();
        repeat (5) @(negedge hclk);
        check_val("wait_rd_stalled", bus.hreadyout, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge hclk);
        check_reset_outputs("midreset_hold");
        rst      = 1'b0;
        model_rd = '0;
        model_wr = '0;
        check_val("midreset_req_count", 64'(req_count), 64'(exp_reqs));
        $display("[%0t] xfer %0d RD addr=%08h aborted by reset", $time, n_xfer + 1, 32'(idx) << 2);
        n_xfer++;
        @(negedge hclk);
        do_xfer(32'h0000_0A94, 1'b0, 3'b010, 32'h0, 1, 2);
        @(negedge hclk);
        do_xfer(32'h0000_0A94, 1'b1, 3'b010, 32'h0BAD_CAFE, 0, 1);
        do_xfer(32'h0000_0A94, 1'b0, 3'b010, 32'h0, 0, 3);

        repeat (3) @(negedge hclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ahb_sdram_slave_if.md
# ahb_sdram_slave_if

AHB-Lite slave front end for the SDRAM memory controller. It accepts single-word AHB transfers, checks the address and size, and converts each valid transfer into a one-request valid/ready handshake toward the controller. It stretches the AHB data phase with `hreadyout` until the write is accepted or the read data returns. It sits directly upstream of the controller's request port (`mem_addr`, `enable`, `w_en`, `r_en`, `BUSYn`).

## Interface
- `ADDR_W`, 12: word-address width toward the controller.
- `DATA_W`, 32: bus and memory data width.
- `BASE_ADDR`, 32'h0000_0000: window base. Only bits [31:ADDR_W+2] are compared.
- `hclk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `hsel` in 1: slave select.
- `haddr` in 32: AHB byte address.
- `htrans` in 2: transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- `hwrite` in 1: 1 = write.
- `hsize` in 3: transfer size.
- `hready` in 1: bus-level ready (previous data phase done).
- `hwdata` in DATA_W: write data, valid during the data phase.
- `hrdata` out DATA_W: read data, registered.
- `hreadyout` out 1: data-phase ready.
- `hresp` out 1: 0 OKAY, 1 ERROR.
- `mem_addr` out ADDR_W: word address to the controller, registered.
- `enable` out 1: request valid, registered.
- `w_en` out 1: write request qualifier, registered.
- `r_en` out 1: read request qualifier, registered.
- `wr_data` out DATA_W: write data to the controller, registered.
- `busy_n` in 1: controller ready. A request is accepted on an edge where `enable` and `busy_n` are both 1.
- `rd_data` in DATA_W: read data from the controller.
- `rd_valid` in 1: one-cycle strobe marking `rd_data` valid.

## Operation
- **Accept condition.** `acc = hsel & hready & htrans[1]`. It is evaluated only in IDLE, DONE and ERR2. IDLE/BUSY transfers, or `acc` in any other state, are ignored and get a zero-wait OKAY.
- **Valid transfer.** All of the following must hold:
  - `haddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]`
  - `haddr[1:0] == 0`
  - `hsize == 3'b010`
- **Latched fields.** On a valid `acc`, latch `haddr[ADDR_W+1:2]`→`mem_addr` and latch `hwrite`.
- **States:**
  - **IDLE**: `hreadyout=1`, `hresp=0`. Valid `acc` → CAPTURE. Invalid `acc` → ERR1.
  - **CAPTURE** (1 cycle): `hreadyout=0`. Register `hwdata`→`wr_data` (writes only). Set `enable=1` and `w_en=hwrite`, `r_en=~hwrite` for the next cycle. → ISSUE.
  - **ISSUE**: `hreadyout=0`. Hold `enable`/`w_en`/`r_en`/`mem_addr`/`wr_data` stable until the edge where `busy_n=1`. On that edge, clear `enable`/`w_en`/`r_en`. Then a write → DONE and a read → WAIT_RD.
  - **WAIT_RD**: `hreadyout=0`. On the edge where `rd_valid=1`, load `rd_data`→`hrdata` and go to DONE. `rd_valid` is ignored in every state other than WAIT_RD.
  - **DONE** (1 cycle): `hreadyout=1`, `hresp=0`. Valid `acc` → CAPTURE. Invalid `acc` → ERR1. Otherwise → IDLE.
  - **ERR1** (1 cycle): `hreadyout=0`, `hresp=1`. No request is issued. → ERR2.
  - **ERR2** (1 cycle): `hreadyout=1`, `hresp=1`. Transitions are the same as in DONE.
- **Output behaviour:**
  - `hreadyout`/`hresp` are decoded from state.
  - Between transfers, `hrdata` holds its last read value.
  - `wr_data` is updated only for writes.
- At most one request is outstanding to the controller.

## Timing
- **Reset values:**
  - State IDLE.
  - `hreadyout=1`, `hresp=0`, `hrdata=0`.
  - `enable=w_en=r_en=0`, `mem_addr=0`, `wr_data=0`.
- **Reset mid-transfer** (any state): the transfer is aborted. Strobes drop asynchronously and no request or response completes.
- **Write latency**, with the accept edge as T0 and `busy_n=1`:
  - CAPTURE occupies T0–T1.
  - `enable` is high T1–T2 and is accepted at T2.
  - DONE follows, so the master sees 2 wait states.
  - Each cycle of `busy_n=0` during ISSUE adds one wait state.
- **Read latency:** 2 wait states plus the ISSUE stall plus the WAIT_RD cycles. A minimum read has 3 wait states.
- **Error response:** exactly 1 wait state, with `hresp=1` in both cycles.
- **Pipelined operation:** back-to-back transfers overlap the next address phase with DONE/ERR2, with no idle cycle.

## Test plan
- **Reset:** assert `rst` mid-WAIT_RD → all outputs return to their reset values immediately. After release, a valid read completes normally.
- **Write:** NONSEQ write, `haddr=0x0000_0010`, `hwdata=0xDEADBEEF`, `busy_n=1` → `enable`/`w_en` high for exactly 1 cycle with `mem_addr=0x004` and `wr_data=0xDEADBEEF`; `hreadyout` low for 2 cycles, then OKAY.
- **Stalled write:** same write with `busy_n=0` for 3 cycles → request held stable for 4 cycles; `hreadyout` low for 5 cycles.
- **Read:** `haddr=0x0000_3FFC`, with `rd_valid` arriving on the 2nd WAIT_RD cycle carrying `0x12345678` → `mem_addr=0xFFF`, `r_en` pulse, `hrdata=0x12345678` in DONE.
- **Errors:**
  - `haddr=0x0001_0000` → ERR1/ERR2 with `hresp=1`, `enable` never asserted.
  - `hsize=3'b000` → same response.
  - `haddr=0x0000_0002` → same response.
- **Back-to-back:** a NONSEQ read presented during DONE of a write → accepted with no IDLE cycle; both requests are seen in order by the controller.
